biquad_sequencer: RTL and testbench
===================================

Name: biquad_sequencer

Overview:
Time-multiplexed IIR cascade engine that replaces per-section biquad instances with one shared 17x12 multiplier and one 29-bit accumulator.
- Per accepted sample, steps through NUM_SECTIONS transposed-direct-form-II sections in order.
- Holds coefficients and delay state in local register files; coefficients are writable at runtime.
- Sits between the 50 kHz ADC sample strobe and the DAC driver, which consumes the offset-binary output.

Parameters:
NUM_SECTIONS, 3, number of cascaded biquad sections (1..8)
DATA_W, 12, sample width, signed Q11
COEF_W, 17, coefficient width, signed Q15
ACC_W, 29, accumulator/delay width, signed Q26
CA_W, 5, coef_addr width; must satisfy 2^CA_W >= 5*NUM_SECTIONS

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  one-cycle strobe: in_sample is valid
in_sample  in  DATA_W  signed Q11 input sample
flush  in  1  clear all delay state; honoured only in IDLE
coef_we  in  1  coefficient write strobe
coef_addr  in  CA_W  section*5 + k, where k: 0=b0 1=b1 2=b2 3=a1 4=a2
coef_wdata  in  COEF_W  signed Q15 coefficient
coef_rej  out  1  one-cycle pulse: write rejected (busy or addr >= 5*NUM_SECTIONS)
busy  out  1  high while a sample is in flight
overrun  out  1  one-cycle pulse: in_valid arrived while busy; sample dropped
out_valid  out  1  one-cycle pulse with each new result
out_sample  out  DATA_W  signed Q11 cascade output, held until next result
dac_out  out  DATA_W  out_sample with MSB inverted (offset binary)

Behaviour:
- Reset values:
  - busy, out_valid, overrun, coef_rej = 0; out_sample = 0; dac_out = 0x800.
  - All delay registers cleared.
  - Coefficients: b0 = 32768 (1.0), all others 0, so the cascade is passthrough.
  - FSM returns to IDLE; an in-flight sample is discarded with no out_valid.
- FSM: IDLE -> B0 -> SAT -> B1 -> A1 -> B2 -> A2; then to B0 of the next section, or to DONE after the last section; DONE -> IDLE.
- Per section s, with x = section input and y = section output:
  - B0: acc = d2[s] + b0*x.
  - SAT: ib = acc[28:26] as signed 3-bit.
    - ib >= 1 -> y = 0x7FF
    - ib < -1 -> y = 0x800
    - else y = acc[26:15]
  - B1: acc = d1[s] + b1*x.
  - A1: d2[s] = acc - a1*y.
  - B2: acc = b2*x.
  - A2: d1[s] = acc - a2*y.
  - y becomes x for section s+1.
- Exactly one multiply per state; products are full-precision signed and sign-extended to ACC_W. Sums wrap at ACC_W; only SAT saturates.
- Timing:
  - in_valid in IDLE is captured; busy = 1 from the next cycle.
  - DONE registers out_sample and pulses out_valid.
  - Latency from in_valid to out_valid = 6*NUM_SECTIONS + 1 cycles (19 at default).
  - Throughput: one sample per 6*NUM_SECTIONS + 2 cycles.
- in_valid while busy (DONE included): sample dropped, overrun pulses the next cycle, state unaffected.
- coef_we:
  - In IDLE with a legal address: write takes effect the next cycle.
  - Otherwise the write is ignored and coef_rej pulses the next cycle.
  - A coefficient written in cycle t applies to a sample accepted at t+1 or later.
- flush in IDLE clears all d1/d2 in one cycle; coefficients are kept; flush while busy is ignored.
- Same-cycle in_valid and coef_we in IDLE: both are accepted, and the sample uses the new coefficient.
- Same-cycle in_valid and flush in IDLE: flush applies first, so the sample sees zero state.

Decomposition:
- Shared package iir_pkg holds:
  - widths DATA_W/COEF_W/ACC_W and the coefficient index constants K_B0..K_A2;
  - the state enum;
  - SAT_POS = 12'h7FF, SAT_NEG = 12'h800, COEF_ONE = 17'sd32768;
  - the saturate function.
- One natural sub-module: biquad_mac. It is the registered multiply-accumulate unit with operand select (acc-add, acc-sub, load), shared by all states.

Test Plan:
- Reset, then in_valid with 0x400 -> out_valid exactly 19 cycles later, out_sample = 0x400, dac_out = 0xC00.
- Write addr 0 = 16384 (b0 = 0.5); x = 0x400 -> out 0x200, dac_out = 0xA00.
- Write addr 3 = -16384 (a1 = -0.5); impulse 0x400 then 0,0 -> outputs 0x400, 0x200, 0x100.
- Write addr 0 = 65535 - 1 (b0 near 2.0); x = 0x7FF -> out 0x7FF; x = 0x800 -> out 0x800. Both saturated.
- Second in_valid 5 cycles after first -> overrun pulse; coef_we while busy -> coef_rej, and the later readback result is unchanged. Then flush in IDLE -> next sample 0 yields 0 despite prior state.
- Assert rst at cycle 10 of a sample -> no out_valid; busy = 0; the next 0x400 yields 0x400 (coefficients back to passthrough).

Source files
------------

// File: rtl/biquad_sequencer_pkg.sv
// iir_pkg: widths, coefficient slot indices, FSM and MAC encodings, and the
// Q26 accumulator -> Q11 sample saturation shared by the biquad cascade.
package iir_pkg;

  localparam int DATA_W    = 12;  // signed Q11 samples
  localparam int COEF_W    = 17;  // signed Q15 coefficients
  localparam int ACC_W     = 29;  // signed Q26 accumulator / delay state
  localparam int COEF_FRAC = 15;  // fractional bits dropped when leaving Q26

  // Coefficient slot inside one section: address = section*NUM_K + k
  localparam int NUM_K = 5;
  localparam int K_B0  = 0;
  localparam int K_B1  = 1;
  localparam int K_B2  = 2;
  localparam int K_A1  = 3;
  localparam int K_A2  = 4;

  localparam logic [DATA_W-1:0]        SAT_POS  = 12'h7FF;
  localparam logic [DATA_W-1:0]        SAT_NEG  = 12'h800;
  localparam logic signed [COEF_W-1:0] COEF_ONE = 17'sd32768;

  // Sequencer states; one multiply per state except SAT/IDLE/DONE
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_SAT  = 3'd2,
    ST_B1   = 3'd3,
    ST_A1   = 3'd4,
    ST_B2   = 3'd5,
    ST_A2   = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  // MAC operand select: keep, addend+product, acc-product, product only
  typedef enum logic [1:0] {
    MAC_HOLD = 2'd0,
    MAC_ADD  = 2'd1,
    MAC_SUB  = 2'd2,
    MAC_LOAD = 2'd3
  } mac_op_e;

  // Integer part of the Q26 value lives in acc[28:26]; anything outside
  // [-1, 1) clips to the Q11 rails, otherwise keep acc[26:15].
  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] acc);
    logic signed [2:0] w_ib;
    w_ib = $signed(acc[ACC_W-1:ACC_W-3]);
    if (w_ib >= 3'sd1) return SAT_POS;
    if (w_ib < 3'sb111) return SAT_NEG;
    return acc[COEF_FRAC+DATA_W-1:COEF_FRAC];
  endfunction

endpackage

// File: rtl/biquad_sequencer_if.sv
// Sample / coefficient / result bus of the biquad sequencer.
// Handshake: in_valid is a one-cycle strobe with no backpressure; the block
// is ready exactly when busy is low, a strobe seen while busy is dropped and
// flagged by overrun one cycle later. out_valid is a one-cycle strobe with
// out_sample/dac_out held until the next result. coef_we is likewise a
// strobe, answered by coef_rej one cycle later when it cannot be taken.
interface biquad_sequencer_if #(
  parameter int CA_W = 5
) ();
  import iir_pkg::*;

  logic                in_valid;
  logic [DATA_W-1:0]   in_sample;
  logic                flush;
  logic                coef_we;
  logic [CA_W-1:0]     coef_addr;
  logic [COEF_W-1:0]   coef_wdata;
  logic                coef_rej;
  logic                busy;
  logic                overrun;
  logic                out_valid;
  logic [DATA_W-1:0]   out_sample;
  logic [DATA_W-1:0]   dac_out;
  state_e              dbg_state;

  modport master (
    output in_valid, in_sample, flush, coef_we, coef_addr, coef_wdata,
    input  coef_rej, busy, overrun, out_valid, out_sample, dac_out, dbg_state
  );

  modport slave (
    input  in_valid, in_sample, flush, coef_we, coef_addr, coef_wdata,
    output coef_rej, busy, overrun, out_valid, out_sample, dac_out, dbg_state
  );

endinterface

// File: rtl/biquad_sequencer_mac.sv
// biquad_mac: the single shared 17x12 multiplier feeding a registered
// 29-bit accumulator. Products are exact and sign-extended; sums wrap.
module biquad_mac
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  mac_op_e                  i_op,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic signed [ACC_W-1:0]  i_addend,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic signed [ACC_W-1:0]  o_sum
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_coef_x;
  logic signed [ACC_W-1:0] w_data_x;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_sum;

  // A 17x12 product always fits in 29 bits, so the low word is exact
  assign w_coef_x = {{(ACC_W-COEF_W){i_coef[COEF_W-1]}}, i_coef};
  assign w_data_x = {{(ACC_W-DATA_W){i_data[DATA_W-1]}}, i_data};
  assign w_prod   = w_coef_x * w_data_x;

  // Operand select for the next accumulator value
  always_comb begin
    w_sum = r_acc;
    case (i_op)
      MAC_HOLD: w_sum = r_acc;
      MAC_ADD:  w_sum = i_addend + w_prod;
      MAC_SUB:  w_sum = r_acc - w_prod;
      MAC_LOAD: w_sum = w_prod;
    endcase
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) r_acc <= '0;
    else     r_acc <= w_sum;
  end

  assign o_acc = r_acc;
  assign o_sum = w_sum;

endmodule

// File: rtl/biquad_sequencer.sv
// biquad_sequencer: time-multiplexed cascade of transposed-DF-II biquads.
// Each accepted sample walks B0,SAT,B1,A1,B2,A2 per section on one shared
// MAC, then DONE publishes the result (Q11 and offset-binary for the DAC).
module biquad_sequencer
  import iir_pkg::*;
#(
  parameter int NUM_SECTIONS = 3,
  parameter int CA_W         = 5
) (
  input  logic              clk,
  input  logic              rst,
  biquad_sequencer_if.slave bus
);

  localparam int NUM_COEF  = NUM_K * NUM_SECTIONS;
  localparam int SEC_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  // Register files are sized to the full index range; slots past the legal
  // range are never written and keep their reset constant.
  localparam int NUM_CSLOT = 1 << CA_W;
  localparam int NUM_DSLOT = 1 << SEC_W;

  state_e                    r_state;
  logic [SEC_W-1:0]          r_sec;
  logic [CA_W-1:0]           r_base;
  logic signed [DATA_W-1:0]  r_x;
  logic signed [DATA_W-1:0]  r_y;
  logic [DATA_W-1:0]         r_out_sample;
  logic                      r_out_valid;
  logic                      r_overrun;
  logic                      r_coef_rej;
  logic signed [COEF_W-1:0]  r_coef [NUM_CSLOT];
  logic signed [ACC_W-1:0]   r_d1   [NUM_DSLOT];
  logic signed [ACC_W-1:0]   r_d2   [NUM_DSLOT];

  logic                      w_idle;
  logic                      w_addr_ok;
  logic                      w_last;
  mac_op_e                   w_op;
  logic [CA_W-1:0]           w_k;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_data;
  logic signed [ACC_W-1:0]   w_addend;
  logic signed [ACC_W-1:0]   w_acc;
  logic signed [ACC_W-1:0]   w_sum;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_addr_ok = (int'(bus.coef_addr) < NUM_COEF);
  assign w_last    = (r_sec == SEC_W'(NUM_SECTIONS - 1));

  biquad_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_op     (w_op),
    .i_coef   (w_coef),
    .i_data   (w_data),
    .i_addend (w_addend),
    .o_acc    (w_acc),
    .o_sum    (w_sum)
  );

  // Per-state MAC operands: feed-forward terms use x, feedback terms use y
  always_comb begin
    w_op     = MAC_HOLD;
    w_k      = CA_W'(K_B0);
    w_data   = r_x;
    w_addend = r_d2[r_sec];
    case (r_state)
      ST_B0: w_op = MAC_ADD;
      ST_B1: begin
        w_op     = MAC_ADD;
        w_k      = CA_W'(K_B1);
        w_addend = r_d1[r_sec];
      end
      ST_A1: begin
        w_op   = MAC_SUB;
        w_k    = CA_W'(K_A1);
        w_data = r_y;
      end
      ST_B2: begin
        w_op = MAC_LOAD;
        w_k  = CA_W'(K_B2);
      end
      ST_A2: begin
        w_op   = MAC_SUB;
        w_k    = CA_W'(K_A2);
        w_data = r_y;
      end
      default: ;
    endcase
  end

  assign w_coef = r_coef[r_base + w_k];

  // Sequencer: capture sample, walk the sections, publish the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sec        <= '0;
      r_base       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= bus.in_valid && !w_idle;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_x     <= bus.in_sample;
            r_sec   <= '0;
            r_base  <= '0;
            r_state <= ST_B0;
          end
        end
        ST_B0:  r_state <= ST_SAT;
        ST_SAT: begin
          r_y     <= saturate(w_acc);
          r_state <= ST_B1;
        end
        ST_B1:  r_state <= ST_A1;
        ST_A1:  r_state <= ST_B2;
        ST_B2:  r_state <= ST_A2;
        ST_A2: begin
          r_x <= r_y;
          if (w_last) begin
            r_out_sample <= r_y;
            r_out_valid  <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_sec   <= r_sec + 1'b1;
            r_base  <= r_base + CA_W'(NUM_K);
            r_state <= ST_B0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Coefficient file: passthrough after reset, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CSLOT; i++)
        r_coef[i] <= (i < NUM_COEF && (i % NUM_K) == K_B0) ? COEF_ONE : '0;
      r_coef_rej <= 1'b0;
    end else begin
      r_coef_rej <= 1'b0;
      if (bus.coef_we) begin
        if (w_idle && w_addr_ok) r_coef[bus.coef_addr] <= bus.coef_wdata;
        else                     r_coef_rej <= 1'b1;
      end
    end
  end

  // Delay state: flush wins in idle, so a same-cycle sample sees zeros
  always_ff @(posedge clk) begin
    if (rst || (w_idle && bus.flush)) begin
      for (int i = 0; i < NUM_DSLOT; i++) begin
        r_d1[i] <= '0;
        r_d2[i] <= '0;
      end
    end else if (r_state == ST_A1) begin
      r_d2[r_sec] <= w_sum;
    end else if (r_state == ST_A2) begin
      r_d1[r_sec] <= w_sum;
    end
  end

  assign bus.busy       = !w_idle;
  assign bus.overrun    = r_overrun;
  assign bus.coef_rej   = r_coef_rej;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sample = r_out_sample;
  assign bus.dac_out    = {~r_out_sample[DATA_W-1], r_out_sample[DATA_W-2:0]};
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_biquad_sequencer.sv
// Bench for biquad_sequencer: a cycle model of the cascade equations checks
// every output each cycle; directed vectors pin hand-computed results.
module tb_biquad_sequencer;
  import iir_pkg::*;

  localparam int N    = 3;
  localparam int CA_W = 5;
  localparam int LAT  = 6 * N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  biquad_sequencer_if #(.CA_W(CA_W)) bus ();

  biquad_sequencer #(.NUM_SECTIONS(N), .CA_W(CA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int              coef_m [5*N];
  longint          d1_m [N];
  longint          d2_m [N];
  int              busy_cnt = 0;
  logic [11:0]     exp_q [$];
  logic [11:0]     exp_out_sample = '0;
  bit              exp_out_valid = 0, exp_busy = 0, exp_overrun = 0, exp_rej = 0;
  bit              model_on = 0;

  function automatic longint wrap(input longint v);
    longint span, r;
    span = longint'(1) << ACC_W;
    r = v & (span - 1);
    if (r >= span / 2) r = r - span;
    return r;
  endfunction

  function automatic int sat_m(input longint acc);
    longint ib;
    ib = acc >>> 26;
    if (ib >= 1) return 2047;
    if (ib < -1) return -2048;
    return int'(acc >>> 15);
  endfunction

  function automatic int run_cascade(input int x_in);
    int x, y;
    longint acc;
    x = x_in;
    for (int s = 0; s < N; s++) begin
      acc     = wrap(d2_m[s] + longint'(coef_m[5*s]) * x);
      y       = sat_m(acc);
      acc     = wrap(d1_m[s] + longint'(coef_m[5*s+1]) * x);
      d2_m[s] = wrap(acc - longint'(coef_m[5*s+3]) * y);
      d1_m[s] = wrap(longint'(coef_m[5*s+2]) * x - longint'(coef_m[5*s+4]) * y);
      x = y;
    end
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5*N; i++) coef_m[i] = (i % 5 == 0) ? 32768 : 0;
    for (int s = 0; s < N; s++) begin d1_m[s] = 0; d2_m[s] = 0; end
    busy_cnt = 0;
    exp_q.delete();
    exp_out_sample = '0;
    exp_out_valid = 0; exp_overrun = 0; exp_rej = 0;
  endtask

  // Model advances on each rising edge from the inputs it sampled
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        model_on = 1;
      end else begin
        exp_overrun = 0; exp_rej = 0; exp_out_valid = 0;
        if (busy_cnt > 0) begin
          if (bus.in_valid) exp_overrun = 1;
          if (bus.coef_we)  exp_rej = 1;
          busy_cnt--;
        end else begin
          if (bus.flush)
            for (int s = 0; s < N; s++) begin d1_m[s] = 0; d2_m[s] = 0; end
          if (bus.coef_we) begin
            if (int'(bus.coef_addr) < 5*N) coef_m[bus.coef_addr] = int'($signed(bus.coef_wdata));
            else exp_rej = 1;
          end
          if (bus.in_valid) begin
            exp_q.push_back(12'(run_cascade(int'($signed(bus.in_sample)))));
            busy_cnt = LAT;
          end
        end
        if (busy_cnt == 1 && exp_q.size() > 0) begin
          exp_out_valid  = 1;
          exp_out_sample = exp_q.pop_front();
        end
      end
      exp_busy = (busy_cnt > 0);
    end
  end

  // Compare process: every output, every cycle, just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_on) begin
        check("busy",       32'(bus.busy),       32'(exp_busy));
        check("overrun",    32'(bus.overrun),    32'(exp_overrun));
        check("coef_rej",   32'(bus.coef_rej),   32'(exp_rej));
        check("out_valid",  32'(bus.out_valid),  32'(exp_out_valid));
        check("out_sample", 32'(bus.out_sample), 32'(exp_out_sample));
        check("dac_out",    32'(bus.dac_out),    32'(exp_out_sample ^ 12'h800));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit iv, input int smp, input bit fl,
                       input bit we, input int addr, input int data);
    @(negedge clk);
    bus.in_valid   = iv;
    bus.in_sample  = 12'(smp);
    bus.flush      = fl;
    bus.coef_we    = we;
    bus.coef_addr  = CA_W'(addr);
    bus.coef_wdata = COEF_W'(data);
    @(negedge clk);
    bus.in_valid = 0; bus.flush = 0; bus.coef_we = 0;
  endtask

  task automatic send(input int smp);            drive(1, smp, 0, 0, 0, 0); endtask
  task automatic wcoef(input int addr, input int d); drive(0, 0, 0, 1, addr, d); endtask
  task automatic do_flush();                     drive(0, 0, 1, 0, 0, 0); endtask

  // Called right after send(): counts cycles from the in_valid cycle
  task automatic wait_result(input string name, input int exp_s, input int exp_d,
                             output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({name, " seen"}, 32'(bus.out_valid), 32'd1);
    check({name, " out_sample"}, 32'(bus.out_sample), 32'(exp_s));
    check({name, " dac_out"}, 32'(bus.dac_out), 32'(exp_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    int lat, ov;
    bus.in_valid = 0; bus.in_sample = '0; bus.flush = 0;
    bus.coef_we = 0; bus.coef_addr = '0; bus.coef_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst busy",       32'(bus.busy),       32'd0);
    check("rst out_valid",  32'(bus.out_valid),  32'd0);
    check("rst out_sample", 32'(bus.out_sample), 32'h000);
    check("rst dac_out",    32'(bus.dac_out),    32'h800);
    check("rst state",      32'(bus.dbg_state),  32'(ST_IDLE));

    // passthrough and latency
    send(12'h400);
    wait_result("pass", 12'h400, 12'hC00, lat);
    check("latency", 32'(lat), 32'd19);

    // b0 = 0.5
    wcoef(0, 16384);
    send(12'h400);
    wait_result("half", 12'h200, 12'hA00, lat);

    // a1 = -0.5 impulse response
    wcoef(0, 32768); wcoef(3, -16384); do_flush();
    send(12'h400); wait_result("imp0", 12'h400, 12'hC00, lat);
    send(0);       wait_result("imp1", 12'h200, 12'hA00, lat);
    send(0);       wait_result("imp2", 12'h100, 12'h900, lat);

    // saturation at both rails
    wcoef(3, 0); wcoef(0, 65534); do_flush();
    send(12'h7FF); wait_result("satp", 12'h7FF, 12'hFFF, lat);
    send(12'h800); wait_result("satn", 12'h800, 12'h000, lat);

    // overrun, rejected busy write, flush
    wcoef(0, 32768); wcoef(3, -16384); do_flush();
    send(12'h400);
    repeat (3) @(negedge clk);
    send(12'h123);
    check("overrun pulse", 32'(bus.overrun), 32'd1);
    wcoef(3, 0);
    check("busy write rej", 32'(bus.coef_rej), 32'd1);
    wait_result("ovr0", 12'h400, 12'hC00, lat);
    send(0);       wait_result("ovr1", 12'h200, 12'hA00, lat);
    do_flush();
    send(0);       wait_result("flushed", 12'h000, 12'h800, lat);

    // same-cycle flush + sample
    send(12'h400);             wait_result("pre", 12'h400, 12'hC00, lat);
    drive(1, 0, 1, 0, 0, 0);   wait_result("flush_iv", 12'h000, 12'h800, lat);

    // same-cycle coefficient write + sample
    drive(1, 12'h400, 0, 1, 0, 16384);
    wait_result("coef_iv", 12'h200, 12'hA00, lat);

    // illegal address in idle
    wcoef(15, 7);
    check("bad addr rej", 32'(bus.coef_rej), 32'd1);

    // reset mid-flight
    send(12'h400);
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid rst busy", 32'(bus.busy), 32'd0);
    ov = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    check("no result after rst", 32'(ov), 32'd0);
    send(12'h400); wait_result("post_rst", 12'h400, 12'hC00, lat);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
